ofdm_symbol_packetizer: RTL and testbench

// Upstream driver for the FFT II sink port of the OFDM modulator (ready latency 0).

---
 rtl/ofdm_symbol_packetizer.sv | 153 +++++++++++++++
 tb/tb_ofdm_symbol_packetizer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_symbol_packetizer.sv
// Frames mapped OFDM subcarriers into FFT_POINTS-beat Avalon-ST packets.
// Each packet starts with sop and ends with eop. DC and guard bins are zero-filled.
module ofdm_symbol_packetizer #(
  parameter int   FFT_POINTS = 64,
  parameter int   GUARD      = 6,
  parameter int   DATA_W     = 16,
  parameter logic INVERSE    = 1'b1
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] in_data,
  output logic                src_valid,
  input  logic                src_ready,
  output logic [1:0]          src_error,
  output logic                src_sop,
  output logic                src_eop,
  output logic [2*DATA_W:0]   src_data,
  output logic                symbol_done
);

  localparam int                K_W     = $clog2(FFT_POINTS);
  localparam logic [K_W-1:0]    K_ZERO  = {K_W{1'b0}};
  localparam logic [K_W-1:0]    K_ONE   = {{(K_W-1){1'b0}}, 1'b1};
  localparam logic [K_W-1:0]    K_LAST  = K_W'(FFT_POINTS - 1);
  localparam logic [K_W-1:0]    NULL_LO = K_W'(FFT_POINTS/2 - GUARD);
  localparam logic [K_W-1:0]    NULL_HI = K_W'(FFT_POINTS/2 + GUARD - 1);
  localparam logic [2*DATA_W:0] NULL_BEAT = {INVERSE, {(2*DATA_W){1'b0}}};

  typedef enum logic [1:0] {
    BIN_DC    = 2'b00,
    BIN_GUARD = 2'b01,
    BIN_DATA  = 2'b10
  } bin_kind_t;

  function automatic bin_kind_t classify_bin(input logic [K_W-1:0] k);
    if (k == K_ZERO) begin
      return BIN_DC;
    end else if ((k >= NULL_LO) && (k <= NULL_HI)) begin
      return BIN_GUARD;
    end else begin
      return BIN_DATA;
    end
  endfunction

  logic [K_W-1:0]    r_k;
  logic              r_valid;
  logic              r_sop;
  logic              r_eop;
  logic [2*DATA_W:0] r_data;
  logic              r_done;

  logic              w_load;
  bin_kind_t         w_kind;
  logic              w_at_last;
  logic [K_W-1:0]    w_nxt_k;
  logic              w_nxt_valid;
  logic              w_nxt_sop;
  logic              w_nxt_eop;
  logic [2*DATA_W:0] w_nxt_data;

  assign w_load    = !r_valid || src_ready;
  assign w_kind    = classify_bin(r_k);
  assign w_at_last = (r_k == K_LAST);

  // Only data bins ever pull a subcarrier, and only when the output slot is free.
  assign in_ready  = w_load && (w_kind == BIN_DATA);

  // Next contents of the output stage for the bin currently addressed by r_k.
  always_comb begin
    w_nxt_k     = r_k;
    w_nxt_valid = 1'b0;
    w_nxt_sop   = 1'b0;
    w_nxt_eop   = 1'b0;
    w_nxt_data  = {(2*DATA_W+1){1'b0}};
    case (w_kind)
      BIN_DC: begin
        // A packet is only opened once a subcarrier is waiting behind it.
        if (in_valid) begin
          w_nxt_valid = 1'b1;
          w_nxt_sop   = 1'b1;
          w_nxt_data  = NULL_BEAT;
          w_nxt_k     = r_k + K_ONE;
        end else begin
          w_nxt_valid = 1'b0;
          w_nxt_k     = r_k;
        end
      end
      BIN_GUARD: begin
        w_nxt_valid = 1'b1;
        w_nxt_eop   = w_at_last;
        w_nxt_data  = NULL_BEAT;
        w_nxt_k     = r_k + K_ONE;
      end
      BIN_DATA: begin
        if (in_valid) begin
          w_nxt_valid = 1'b1;
          w_nxt_eop   = w_at_last;
          w_nxt_data  = {INVERSE, in_data};
          w_nxt_k     = r_k + K_ONE;
        end else begin
          w_nxt_valid = 1'b0;
          w_nxt_k     = r_k;
        end
      end
      default: begin
        w_nxt_valid = 1'b0;
        w_nxt_k     = r_k;
      end
    endcase
  end

  // Output stage and bin counter; both advance only when the slot is free.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_k     <= K_ZERO;
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_data  <= {(2*DATA_W+1){1'b0}};
    end else if (w_load) begin
      r_k     <= w_nxt_k;
      r_valid <= w_nxt_valid;
      r_sop   <= w_nxt_sop;
      r_eop   <= w_nxt_eop;
      r_data  <= w_nxt_data;
    end else begin
      r_k     <= r_k;
      r_valid <= r_valid;
      r_sop   <= r_sop;
      r_eop   <= r_eop;
      r_data  <= r_data;
    end
  end

  // Symbol-complete pulse, one cycle after the eop beat is taken by the sink.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= r_valid && src_ready && r_eop;
    end
  end

  assign src_valid   = r_valid;
  assign src_sop     = r_sop;
  assign src_eop     = r_eop;
  assign src_data    = r_data;
  assign src_error   = 2'b00;
  assign symbol_done = r_done;

endmodule

// File: tb/tb_ofdm_symbol_packetizer.sv
// Randomised and directed bench for ofdm_symbol_packetizer, checked every cycle
// against a bin-sequence model built from the symbol layout.
module tb_ofdm_symbol_packetizer;

  localparam int   N   = 64;
  localparam int   G   = 6;
  localparam int   DW  = 16;
  localparam logic INV = 1'b1;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] in_data;
  logic            src_valid;
  logic            src_ready;
  logic [1:0]      src_error;
  logic            src_sop;
  logic            src_eop;
  logic [2*DW:0]   src_data;
  logic            symbol_done;

  ofdm_symbol_packetizer #(
    .FFT_POINTS(N), .GUARD(G), .DATA_W(DW), .INVERSE(INV)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_error    (src_error),
    .src_sop      (src_sop),
    .src_eop      (src_eop),
    .src_data     (src_data),
    .symbol_done  (symbol_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_null(input int b);
    return (b == 0) || ((b >= N/2 - G) && (b <= N/2 + G - 1));
  endfunction

  // Model: the sink must see bins 0..N-1 in order; data bins draw accepted inputs FIFO.
  logic [2*DW-1:0] mq[$];
  logic [34:0]     beat_log[$];
  int              mb = 0;
  bit              done_pend = 1'b0;
  bit              hold_v = 1'b0;
  logic [2*DW:0]   hold_d;
  logic            hold_sop, hold_eop;
  bit              in_sym = 1'b0;
  int              inv_cnt = 0;
  int              done_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      mb = 0;
      done_pend = 1'b0;
      hold_v = 1'b0;
      in_sym = 1'b0;
    end else begin
      int          nb;
      logic [2*DW:0] exp_d;
      chk("symbol_done", symbol_done, done_pend);
      chk("src_error", src_error, 2'b00);
      if (hold_v) begin
        chk("stall_valid", src_valid, 1'b1);
        chk("stall_data", src_data, hold_d);
        chk("stall_sop", src_sop, hold_sop);
        chk("stall_eop", src_eop, hold_eop);
      end
      nb = src_valid ? (mb + 1) % N : mb;
      chk("in_ready", in_ready, (!src_valid || src_ready) && !is_null(nb));
      if (src_valid) chk("inverse_bit", src_data[2*DW], INV);
      done_pend = 1'b0;
      if (src_valid && src_ready) begin
        exp_d = {INV, {(2*DW){1'b0}}};
        if (!is_null(mb)) begin
          chk("model_input_available", mq.size() != 0, 1'b1);
          if (mq.size() != 0) exp_d = {INV, mq.pop_front()};
        end
        chk("beat_data", src_data, exp_d);
        chk("beat_sop", src_sop, mb == 0);
        chk("beat_eop", src_eop, mb == N - 1);
        beat_log.push_back({src_sop, src_eop, src_data});
        if (mb == 0) in_sym = 1'b1;
        if (mb == N - 1) begin
          in_sym = 1'b0;
          done_pend = 1'b1;
        end
        mb = (mb + 1) % N;
      end else if (!src_valid && in_sym) begin
        inv_cnt++;
      end
      if (in_valid && in_ready) mq.push_back(in_data);
      if (symbol_done) done_cnt++;
      hold_v   = src_valid && !src_ready;
      hold_d   = src_data;
      hold_sop = src_sop;
      hold_eop = src_eop;
    end
  end

  int n_acc = 0;
  int seq_val = 0;
  bit seq_mode = 1'b1;

  // One clock: note acceptance before the edge, advance the source after it.
  task automatic step();
    bit acc;
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      n_acc++;
      if (seq_mode) begin
        seq_val++;
        in_data = 32'(seq_val);
      end else begin
        in_data = $urandom;
      end
    end
  endtask

  task automatic wait_acc(input int target);
    for (int i = 0; i < 300 && n_acc < target; i++) step();
    chk("acc_reached", n_acc >= target, 1'b1);
  endtask

  task automatic chk_beat(input string nm, input int idx, input logic [32:0] d,
                          input logic sop, input logic eop);
    logic [34:0] e;
    chk({nm, "_present"}, beat_log.size() > idx, 1'b1);
    if (beat_log.size() > idx) begin
      e = beat_log[idx];
      chk({nm, "_data"}, e[32:0], d);
      chk({nm, "_sop"}, e[34], sop);
      chk({nm, "_eop"}, e[33], eop);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, d0, i0;
    rst_n = 1'b0; in_valid = 1'b0; src_ready = 1'b1; in_data = '0;
    #1;
    chk("rst_valid", src_valid, 1'b0);
    chk("rst_sop", src_sop, 1'b0);
    chk("rst_eop", src_eop, 1'b0);
    chk("rst_data", src_data, 33'h0);
    chk("rst_done", symbol_done, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle, then one symbol of 1..51 with continuous flow.
    repeat (20) begin step(); chk("idle_valid", src_valid, 1'b0); end
    seq_mode = 1'b1; seq_val = 1; in_data = 32'd1; n_acc = 0;
    s = beat_log.size(); d0 = done_cnt;
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("first_sop_valid", src_valid, 1'b1);
    chk("first_sop", src_sop, 1'b1);
    repeat (63) step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("t1_beats", beat_log.size() - s, 64);
    chk("t1_done", done_cnt - d0, 1);
    chk_beat("t1_b0", s + 0, 33'h1_0000_0000, 1'b1, 1'b0);
    chk_beat("t1_b1", s + 1, 33'h1_0000_0001, 1'b0, 1'b0);
    chk_beat("t1_b25", s + 25, 33'h1_0000_0019, 1'b0, 1'b0);
    chk_beat("t1_b26", s + 26, 33'h1_0000_0000, 1'b0, 1'b0);
    chk_beat("t1_b37", s + 37, 33'h1_0000_0000, 1'b0, 1'b0);
    chk_beat("t1_b38", s + 38, 33'h1_0000_001A, 1'b0, 1'b0);
    chk_beat("t1_b63", s + 63, 33'h1_0000_0033, 1'b0, 1'b1);

    // Starvation at the 10th data bin, and no input across the null band.
    seq_val = 1; in_data = 32'd1; n_acc = 0;
    s = beat_log.size(); i0 = inv_cnt;
    in_valid = 1'b1;
    wait_acc(9);
    in_valid = 1'b0; repeat (5) step();
    in_valid = 1'b1; wait_acc(25);
    in_valid = 1'b0; repeat (12) step();
    in_valid = 1'b1; wait_acc(51);
    in_valid = 1'b0; repeat (4) step();
    chk("t3_beats", beat_log.size() - s, 64);
    chk("t3_gap_cycles", inv_cnt - i0, 5);
    chk_beat("t3_b10", s + 10, 33'h1_0000_000A, 1'b0, 1'b0);
    chk_beat("t3_b38", s + 38, 33'h1_0000_001A, 1'b0, 1'b0);
    chk_beat("t3_b63", s + 63, 33'h1_0000_0033, 1'b0, 1'b1);

    // Three back-to-back symbols.
    seq_val = 1; in_data = 32'd1; n_acc = 0;
    s = beat_log.size(); d0 = done_cnt; i0 = inv_cnt;
    in_valid = 1'b1;
    repeat (192) step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("b2b_beats", beat_log.size() - s, 192);
    chk("b2b_inputs", n_acc, 153);
    chk("b2b_done", done_cnt - d0, 3);
    chk("b2b_gaps", inv_cnt - i0, 0);
    chk_beat("b2b_63", s + 63, 33'h1_0000_0033, 1'b0, 1'b1);
    chk_beat("b2b_64", s + 64, 33'h1_0000_0000, 1'b1, 1'b0);
    chk_beat("b2b_65", s + 65, 33'h1_0000_0034, 1'b0, 1'b0);
    chk_beat("b2b_127", s + 127, 33'h1_0000_0066, 1'b0, 1'b1);
    chk_beat("b2b_128", s + 128, 33'h1_0000_0000, 1'b1, 1'b0);
    chk_beat("b2b_191", s + 191, 33'h1_0000_0099, 1'b0, 1'b1);

    // Backpressure pattern 1,0,0 with random data.
    seq_mode = 1'b0; in_data = $urandom; s = beat_log.size();
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      src_ready = ((i % 3) == 0);
      step();
    end
    chk("toggle_progress", (beat_log.size() - s) >= 50, 1'b1);

    // Fully random flow control.
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      src_ready = ($urandom_range(9) < 7);
      step();
    end

    // Reset while bin 40 sits in the output stage.
    in_valid = 1'b1; src_ready = 1'b1;
    step();
    for (int i = 0; i < 300 && mb != 40; i++) step();
    chk("reached_beat40", mb, 40);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid_rst_valid", src_valid, 1'b0);
    chk("mid_rst_sop", src_sop, 1'b0);
    chk("mid_rst_eop", src_eop, 1'b0);
    chk("mid_rst_data", src_data, 33'h0);
    chk("mid_rst_done", symbol_done, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; in_valid = 1'b1; src_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", src_valid, 1'b1);
    chk("post_rst_sop", src_sop, 1'b1);
    chk("post_rst_data", src_data, 33'h1_0000_0000);
    d0 = done_cnt;
    repeat (66) step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("post_rst_done", done_cnt - d0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
